// File: rtl/vga_field_pkg.sv
// Shared types and constants for the VGA field snapshot front-end.
package vga_field_pkg;

  localparam int unsigned CHAR_W = 7;
  localparam logic [CHAR_W-1:0] ASCII_ZERO = 7'h30;
  localparam logic [CHAR_W-1:0] ASCII_DASH = 7'h2D;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_CAPTURE     = 2'd1,
    ST_COMMIT      = 2'd2,
    ST_WAIT_ACTIVE = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_ascii_digit.sv
// Combinational BCD nibble to ASCII digit.
// VGA_FIELD_BCD_CHECK_EN: non-decimal nibbles render as '-' instead of raw passthrough.
module bcd_ascii_digit
  import vga_field_pkg::*;
(
  input  logic [3:0]        nibble,
  output logic [CHAR_W-1:0] ascii_c
);

  always_comb begin
    ascii_c = {3'b011, nibble};
`ifdef VGA_FIELD_BCD_CHECK_EN
    if (nibble > 4'd9) ascii_c = ASCII_DASH;
`else
    ascii_c = {3'b011, nibble};
`endif
  end

endmodule

// File: rtl/vga_field_snapshot.sv
// Captures BCD fields during vertical blanking and publishes a frame-stable ASCII bank,
// cursor blink mask and alarm flash flag. Optional digit check: VGA_FIELD_BCD_CHECK_EN.
module vga_field_snapshot
  import vga_field_pkg::*;
#(
  parameter int unsigned NUM_FIELDS   = 11,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned FLASH_FRAMES = 15
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [9:0]                     pixely,
  input  logic [NUM_FIELDS*8-1:0]        fields_in,
  input  logic [7:0]                     cursor,
  input  logic                           edit_mode,
  input  logic                           ring,
  output logic [NUM_FIELDS*2*CHAR_W-1:0] chars_out,
  output logic [NUM_FIELDS-1:0]          blink_mask,
  output logic                           alarm_active,
  output logic                           frame_tick,
  output logic                           capturing
);

  localparam int unsigned IDX_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int unsigned BLK_W  = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned FLS_W  = $clog2(FLASH_FRAMES + 1);
  localparam int unsigned PAIR_W = 2 * CHAR_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FIELDS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [FLS_W-1:0] FLS_LAST = FLS_W'(FLASH_FRAMES - 1);

  state_e state_q, state_d;
  logic   vb_q, vb_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_FIELDS-1:0][PAIR_W-1:0] shadow_q, shadow_d;
  logic [NUM_FIELDS*PAIR_W-1:0] chars_q, chars_d;
  logic [NUM_FIELDS-1:0] mask_q, mask_d;
  logic alarm_q, alarm_d, tick_q, tick_d, capturing_q, capturing_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_phase_q, blink_phase_d;
  logic [FLS_W-1:0] flash_cnt_q, flash_cnt_d;
  logic flash_phase_q, flash_phase_d;
  logic [7:0] cur_field_c;
  logic [CHAR_W-1:0] tens_c, units_c;
  logic [NUM_FIELDS-1:0] onehot_c;

  assign vb_d = (pixely >= 10'(V_ACTIVE));

  // Field selected by the capture index, converted one field per cycle.
  always_comb begin
    cur_field_c = '0;
    onehot_c    = '0;
    for (int unsigned k = 0; k < NUM_FIELDS; k++) begin
      if (idx_q == IDX_W'(k)) cur_field_c = fields_in[8*k +: 8];
      onehot_c[k] = (cursor == 8'(k));
    end
  end

  bcd_ascii_digit u_tens  (.nibble(cur_field_c[7:4]), .ascii_c(tens_c));
  bcd_ascii_digit u_units (.nibble(cur_field_c[3:0]), .ascii_c(units_c));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Dropping out of blanking mid-capture aborts without a commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (vb_d && !vb_q) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (!vb_d)                  state_d = ST_IDLE;
        else if (idx_q == IDX_LAST) state_d = ST_COMMIT;
      end
      ST_COMMIT:      state_d = ST_WAIT_ACTIVE;
      ST_WAIT_ACTIVE: if (!vb_d) state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    chars_d       = chars_q;
    mask_d        = mask_q;
    alarm_d       = alarm_q;
    tick_d        = 1'b0;
    capturing_d   = (state_d == ST_CAPTURE);
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    flash_cnt_d   = flash_cnt_q;
    flash_phase_d = flash_phase_q;
    case (state_q)
      ST_IDLE: idx_d = '0;
      ST_CAPTURE: begin
        shadow_d[idx_q] = {tens_c, units_c};
        idx_d           = idx_q + IDX_W'(1);
      end
      ST_COMMIT: begin
        chars_d = shadow_q;
        tick_d  = 1'b1;
        // Leaving edit mode restarts the blink so the field shows at once on re-entry.
        if (edit_mode) begin
          mask_d = onehot_c & {NUM_FIELDS{blink_phase_q}};
          if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLK_W'(1);
          end
        end else begin
          mask_d        = '0;
          blink_cnt_d   = '0;
          blink_phase_d = 1'b0;
        end
        if (ring) begin
          alarm_d = ~flash_phase_q;
          if (flash_cnt_q == FLS_LAST) begin
            flash_cnt_d   = '0;
            flash_phase_d = ~flash_phase_q;
          end else begin
            flash_cnt_d = flash_cnt_q + FLS_W'(1);
          end
        end else begin
          alarm_d       = 1'b0;
          flash_cnt_d   = '0;
          flash_phase_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vb_q          <= 1'b0;
      idx_q         <= '0;
      shadow_q      <= {(2*NUM_FIELDS){ASCII_ZERO}};
      chars_q       <= {(2*NUM_FIELDS){ASCII_ZERO}};
      mask_q        <= '0;
      alarm_q       <= 1'b0;
      tick_q        <= 1'b0;
      capturing_q   <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      flash_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
    end else begin
      vb_q          <= vb_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      chars_q       <= chars_d;
      mask_q        <= mask_d;
      alarm_q       <= alarm_d;
      tick_q        <= tick_d;
      capturing_q   <= capturing_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      flash_cnt_q   <= flash_cnt_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  assign chars_out    = chars_q;
  assign blink_mask   = mask_q;
  assign alarm_active = alarm_q;
  assign frame_tick   = tick_q;
  assign capturing    = capturing_q;

endmodule

// File: tb/tb_vga_field_snapshot.sv
// Directed bench for vga_field_snapshot: capture latency, tearing, abort, blink and flash.
module tb_vga_field_snapshot;

  localparam int NF    = 11;
  localparam int BLINK = 2;
  localparam int FLASH = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [9:0]       pixely;
  logic [NF*8-1:0]  fields_in;
  logic [7:0]       cursor;
  logic             edit_mode;
  logic             ring;
  logic [NF*14-1:0] chars_out;
  logic [NF-1:0]    blink_mask;
  logic             alarm_active;
  logic             frame_tick;
  logic             capturing;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_field_snapshot #(
    .NUM_FIELDS(NF), .V_ACTIVE(480), .BLINK_FRAMES(BLINK), .FLASH_FRAMES(FLASH)
  ) dut (
    .clk(clk), .reset(reset), .pixely(pixely), .fields_in(fields_in),
    .cursor(cursor), .edit_mode(edit_mode), .ring(ring),
    .chars_out(chars_out), .blink_mask(blink_mask), .alarm_active(alarm_active),
    .frame_tick(frame_tick), .capturing(capturing)
  );

  typedef struct packed {
    logic [7:0]  f0;
    logic        edit;
    logic [7:0]  cur;
    logic        rng;
    logic [10:0] exp_mask;
    logic        exp_alarm;
    logic [13:0] exp_f0;
  } vec_t;

  vec_t vecs [26];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] fchars(input int k);
    return chars_out[14*k +: 14];
  endfunction

  // One frame: a few visible lines, then blanking until the commit pulse (bounded).
  task automatic run_frame(output bit got);
    got = 1'b0;
    @(negedge clk) pixely = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) pixely = 10'd480;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (frame_tick) got = 1'b1;
    end
    repeat (2) @(posedge clk);
  endtask

  logic [NF*14-1:0] zeros_exp;
  logic [NF*14-1:0] saved;
  logic [13:0]      f1_exp;
  bit               got;
  bit               saw_tick;

  initial begin
    for (int i = 0; i < 2*NF; i++) zeros_exp[7*i +: 7] = 7'h30;
`ifdef VGA_FIELD_BCD_CHECK_EN
    f1_exp = {7'h33, 7'h2D};
`else
    f1_exp = {7'h33, 7'h3C};
`endif
    //          f0     ed    cur    rng   mask     al    chars(tens,units)
    vecs[0]  = '{8'h00, 1'b1, 8'd3,  1'b0, 11'h000, 1'b0, {7'h30, 7'h30}};
    vecs[1]  = '{8'h01, 1'b1, 8'd3,  1'b0, 11'h000, 1'b0, {7'h30, 7'h31}};
    vecs[2]  = '{8'h02, 1'b1, 8'd3,  1'b0, 11'h008, 1'b0, {7'h30, 7'h32}};
    vecs[3]  = '{8'h03, 1'b1, 8'd3,  1'b0, 11'h008, 1'b0, {7'h30, 7'h33}};
    vecs[4]  = '{8'h04, 1'b1, 8'd3,  1'b0, 11'h000, 1'b0, {7'h30, 7'h34}};
    vecs[5]  = '{8'h05, 1'b1, 8'd3,  1'b0, 11'h000, 1'b0, {7'h30, 7'h35}};
    vecs[6]  = '{8'h06, 1'b1, 8'd3,  1'b0, 11'h008, 1'b0, {7'h30, 7'h36}};
    vecs[7]  = '{8'h07, 1'b1, 8'd3,  1'b0, 11'h008, 1'b0, {7'h30, 7'h37}};
    vecs[8]  = '{8'h08, 1'b1, 8'd3,  1'b0, 11'h000, 1'b0, {7'h30, 7'h38}};
    vecs[9]  = '{8'h09, 1'b1, 8'd3,  1'b0, 11'h000, 1'b0, {7'h30, 7'h39}};
    vecs[10] = '{8'h10, 1'b0, 8'd3,  1'b0, 11'h000, 1'b0, {7'h31, 7'h30}};
    vecs[11] = '{8'h11, 1'b1, 8'd11, 1'b0, 11'h000, 1'b0, {7'h31, 7'h31}};
    vecs[12] = '{8'h12, 1'b1, 8'd0,  1'b0, 11'h000, 1'b0, {7'h31, 7'h32}};
    vecs[13] = '{8'h13, 1'b1, 8'd0,  1'b0, 11'h001, 1'b0, {7'h31, 7'h33}};
    vecs[14] = '{8'h14, 1'b1, 8'd11, 1'b0, 11'h000, 1'b0, {7'h31, 7'h34}};
    vecs[15] = '{8'h15, 1'b0, 8'd0,  1'b0, 11'h000, 1'b0, {7'h31, 7'h35}};
    vecs[16] = '{8'h16, 1'b0, 8'd0,  1'b1, 11'h000, 1'b1, {7'h31, 7'h36}};
    vecs[17] = '{8'h17, 1'b0, 8'd0,  1'b1, 11'h000, 1'b1, {7'h31, 7'h37}};
    vecs[18] = '{8'h18, 1'b0, 8'd0,  1'b1, 11'h000, 1'b1, {7'h31, 7'h38}};
    vecs[19] = '{8'h19, 1'b0, 8'd0,  1'b1, 11'h000, 1'b0, {7'h31, 7'h39}};
    vecs[20] = '{8'h20, 1'b0, 8'd0,  1'b1, 11'h000, 1'b0, {7'h32, 7'h30}};
    vecs[21] = '{8'h21, 1'b0, 8'd0,  1'b1, 11'h000, 1'b0, {7'h32, 7'h31}};
    vecs[22] = '{8'h22, 1'b0, 8'd0,  1'b1, 11'h000, 1'b1, {7'h32, 7'h32}};
    vecs[23] = '{8'h23, 1'b0, 8'd0,  1'b1, 11'h000, 1'b1, {7'h32, 7'h33}};
    vecs[24] = '{8'h24, 1'b0, 8'd0,  1'b1, 11'h000, 1'b1, {7'h32, 7'h34}};
    vecs[25] = '{8'h25, 1'b0, 8'd0,  1'b0, 11'h000, 1'b0, {7'h32, 7'h35}};

    reset     = 1'b0;
    pixely    = 10'd0;
    fields_in = '0;
    fields_in[7:0]  = 8'h59;
    fields_in[15:8] = 8'h3C;
    cursor    = 8'd0;
    edit_mode = 1'b0;
    ring      = 1'b0;

    #23;
    check("reset_chars", chars_out, zeros_exp);
    check("reset_mask", blink_mask, 11'h000);
    check("reset_alarm", alarm_active, 1'b0);
    check("reset_tick", frame_tick, 1'b0);
    check("reset_capturing", capturing, 1'b0);

    @(negedge clk) reset = 1'b1;
    repeat (3) @(posedge clk);

    // Commit latency: chars appear together with the tick 13 edges after blanking starts.
    @(negedge clk) pixely = 10'd480;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk); #1;
      if (e == 2) check("capturing_high", capturing, 1'b1);
      if (e == 12) begin
        check("pre_commit_f0", fchars(0), {7'h30, 7'h30});
        check("pre_commit_tick", frame_tick, 1'b0);
      end
      if (e == 13) begin
        check("commit_f0", fchars(0), {7'h35, 7'h39});
        check("commit_f1_hex", fchars(1), f1_exp);
        check("commit_tick", frame_tick, 1'b1);
      end
    end
    @(posedge clk); #1;
    check("tick_one_cycle", frame_tick, 1'b0);
    check("capturing_low", capturing, 1'b0);

    // Input churn outside the capture window never reaches the display.
    saved = chars_out;
    @(negedge clk) pixely = 10'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) fields_in = 88'({$urandom(), $urandom(), $urandom()});
      @(posedge clk); #1;
      check("no_tear_visible", chars_out, saved);
    end
    @(negedge clk);
    for (int k = 0; k < NF; k++) fields_in[8*k +: 8] = 8'h12;
    fields_in[7:0] = 8'h47;
    pixely = 10'd480;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) fields_in[7:0] = 8'h99;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      if (frame_tick) got = 1'b1;
    end
    check("tear_tick", got, 1'b1);
    check("tear_f0", fchars(0), {7'h34, 7'h37});
    check("tear_f5", fchars(5), {7'h31, 7'h32});
    saved = chars_out;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) fields_in = 88'({$urandom(), $urandom(), $urandom()});
      @(posedge clk); #1;
      check("no_tear_blank", chars_out, saved);
    end

    // Abort: blanking ends after 5 capture cycles, nothing commits.
    @(negedge clk) pixely = 10'd0;
    for (int k = 0; k < NF; k++) fields_in[8*k +: 8] = 8'h88;
    fields_in[7:0] = 8'h66;
    repeat (3) @(posedge clk);
    @(negedge clk) pixely = 10'd480;
    repeat (6) @(posedge clk);
    @(negedge clk) pixely = 10'd0;
    saw_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (frame_tick) saw_tick = 1'b1;
    end
    check("abort_no_tick", saw_tick, 1'b0);
    check("abort_keep_chars", chars_out, saved);
    run_frame(got);
    check("after_abort_tick", got, 1'b1);
    check("after_abort_f0", fchars(0), {7'h36, 7'h36});
    check("after_abort_f3", fchars(3), {7'h38, 7'h38});

    // Frame-by-frame blink and flash table.
    fields_in[15:8] = 8'h3C;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      fields_in[7:0] = vecs[i].f0;
      edit_mode      = vecs[i].edit;
      cursor         = vecs[i].cur;
      ring           = vecs[i].rng;
      run_frame(got);
      check($sformatf("vec%0d_tick", i), got, 1'b1);
      check($sformatf("vec%0d_mask", i), blink_mask, vecs[i].exp_mask);
      check($sformatf("vec%0d_alarm", i), alarm_active, vecs[i].exp_alarm);
      check($sformatf("vec%0d_f0", i), fchars(0), vecs[i].exp_f0);
    end
    check("table_f1_hex", fchars(1), f1_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_field_snapshot.md
Name: vga_field_snapshot

Overview:
- Parametrised successor of the RTC display interface front-end.
- Captures NUM_FIELDS packed-BCD fields (clock, date, timer) once per frame during vertical blanking and converts each to two ASCII digits.
- Publishes a frame-stable character bank, a cursor blink mask and an alarm flash flag to the character renderer.
- Sits between the RTC register bank and the renderer, driven by the VGA sync generator's pixely/video_on.

Parameters:
- NUM_FIELDS, 11, number of 8-bit BCD fields captured.
- V_ACTIVE, 480, first non-visible line; capture starts here.
- BLINK_FRAMES, 30, frames per cursor blink half-period (>=1).
- FLASH_FRAMES, 15, frames per alarm flash half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- pixely  in  10  current line from the VGA sync generator.
- fields_in  in  NUM_FIELDS*8  field k at bits [8k+7:8k]; high nibble is tens, low nibble is units.
- cursor  in  8  index of the field under edit.
- edit_mode  in  1  enables cursor blink.
- ring  in  1  alarm request, level.
- chars_out  out  NUM_FIELDS*14  field k: units ASCII at [14k+6:14k], tens ASCII at [14k+13:14k+7].
- blink_mask  out  NUM_FIELDS  1 means the renderer blanks that field this frame.
- alarm_active  out  1  flash phase for the alarm band.
- frame_tick  out  1  one-cycle pulse on commit.
- capturing  out  1  high while state is CAPTURE.

Behaviour:
- Reset, asynchronous, reset low:
  - chars_out = 7'h30 in every digit ("00").
  - blink_mask = 0, alarm_active = 0, frame_tick = 0, capturing = 0.
  - Frame counters = 0, state = IDLE.
- FSM states: IDLE, CAPTURE, COMMIT, WAIT_ACTIVE.
- vb = registered (pixely >= V_ACTIVE). A capture is triggered when vb rises, i.e. vb was 0 and is now 1.
- IDLE -> CAPTURE on the trigger. idx = 0, capturing = 1.
- CAPTURE: one field per cycle.
  - shadow[idx] <= converted fields_in[idx]; idx++.
  - After idx = NUM_FIELDS-1 -> COMMIT.
  - Capture takes NUM_FIELDS cycles.
- COMMIT, one cycle:
  - shadow copied to chars_out.
  - blink_mask and alarm_active updated.
  - frame_tick = 1.
  - -> WAIT_ACTIVE.
  - chars_out therefore changes NUM_FIELDS+2 cycles after pixely first reaches V_ACTIVE.
- WAIT_ACTIVE -> IDLE when vb = 0. A frame never commits twice.
- Abort: if vb falls during CAPTURE (sync generator reset), go to IDLE with no commit. The shadow is discarded and outputs keep the previous frame.
- Conversion: digit = {3'b011, nibble}. Nibble 0–9 gives '0'–'9'.
- Blink:
  - blink_cnt counts committed frames 0..BLINK_FRAMES-1 and wraps. blink_phase toggles on each wrap.
  - At COMMIT: blink_mask = one-hot(cursor) & {NUM_FIELDS{edit_mode & blink_phase}}.
  - cursor >= NUM_FIELDS gives mask 0.
  - When edit_mode is low at COMMIT, blink_cnt and blink_phase are cleared, so the field is visible immediately when edit is entered.
- Alarm flash:
  - ring sampled at COMMIT.
  - ring = 1: flash_cnt runs 0..FLASH_FRAMES-1 and alarm_active toggles on wrap. The first frame after ring rises has alarm_active = 1.
  - ring = 0: flash_cnt = 0 and alarm_active = 0.
- All outputs change only at COMMIT except capturing. Mid-frame changes on inputs never tear the display.

Optional Feature:
- Macro: VGA_FIELD_BCD_CHECK_EN.
- Defined: a nibble > 9 is replaced by '-' (7'h2D) for that digit only.
- Undefined: raw {3'b011, nibble} is passed through (e.g. nibble A gives ':').

Decomposition:
- Package vga_field_pkg holds:
  - state enum.
  - ASCII_ZERO = 7'h30, ASCII_DASH = 7'h2D.
  - CHAR_W = 7.
- Sub-module bcd_ascii_digit: combinational nibble -> 7-bit ASCII, with the macro-controlled check inside. It is instantiated twice, for tens and units, on the CAPTURE datapath.

Test Plan:
- Reset low, then release with fields_in[7:0] = 8'h59 and pixely ramped to 480 -> chars_out field0 stays 7'h30/7'h30 until NUM_FIELDS+2 cycles (13) after pixely = 480. Then units = 7'h39, tens = 7'h35, with one frame_tick pulse.
- Change fields_in every cycle while pixely < 480 -> chars_out is unchanged. Only the values present during the CAPTURE cycles appear at commit.
- edit_mode = 1, cursor = 3, BLINK_FRAMES = 2, run 8 frames -> blink_mask = 0 for frames 1–2, then 11'h008 for frames 3–4, then alternating. Setting cursor = 11 gives 0.
- ring = 1 for 3*FLASH_FRAMES frames, then 0 -> alarm_active is 1, 0, 1 in FLASH_FRAMES-frame blocks, then 0 at the next commit after ring falls.
- Force pixely back to 0 after 5 CAPTURE cycles -> no frame_tick and chars_out keeps the prior frame. The next normal frame commits correctly.
- fields_in[15:8] = 8'h3C -> with VGA_FIELD_BCD_CHECK_EN the units digit = 7'h2D; without it the units digit = 7'h3C. The tens digit = 7'h33 in both cases.
